antirrebote_d: RTL and testbench
================================

Name: antirrebote_d

Overview:
Input-conditioning stage that sits directly upstream of flip_flop_d. It takes a raw, asynchronous, bouncy signal (push-button or switch) and drives the D input of the flip-flop stage with a clean, synchronized, debounced level. It also produces single-cycle rise/fall pulses and a wrapping count of accepted rising edges, for use in later sequential exercises.

Parameters:
STABLE_CYCLES, 4, consecutive synchronized cycles at the new level required before the output changes; must be >= 1
CNT_W, 3, width of the internal stability counter; must satisfy 2^CNT_W >= STABLE_CYCLES
EV_W, 8, width of the accepted-rising-edge event counter

Ports:
clk  input  1  single system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
d_in  input  1  raw asynchronous input; may bounce or glitch
q  output  1  debounced, synchronized level; connects to flip_flop_d.d
rise  output  1  one-cycle pulse, asserted on the edge where q goes 0->1
fall  output  1  one-cycle pulse, asserted on the edge where q goes 1->0
count  output  EV_W  number of accepted rising edges, modulo 2^EV_W

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No other clocks or resets.
- Reset (rst=1 at a clk edge): s1=s2=0, state=ESTABLE_BAJO, cnt=0, q=0, rise=0, fall=0, count=0. rst overrides every other event on that edge. Reset mid-wait abandons the pending transition.
- Synchronizer: two-flop chain. s1<=d_in, s2<=s1. The FSM reads only s2. d_in is never used combinationally.
- FSM states: ESTABLE_BAJO (q=0), ESPERA_ALTO (q=0), ESTABLE_ALTO (q=1), ESPERA_BAJO (q=1).
  - ESTABLE_BAJO: if s2=1, go to ESPERA_ALTO with cnt<=0. Otherwise stay.
  - ESPERA_ALTO: if s2=0, go to ESTABLE_BAJO with cnt<=0 (bounce rejected, no pulse).
    - Else if cnt==STABLE_CYCLES-1, go to ESTABLE_ALTO with q<=1, rise<=1, count<=count+1.
    - Else cnt<=cnt+1.
  - ESTABLE_ALTO and ESPERA_BAJO: mirror of the two states above with the levels inverted. Accepting the transition sets q<=0 and fall<=1. count is unchanged on a fall.
- Pulses: rise and fall are registered and high for exactly one cycle, on the same edge q changes. They are never both high. Otherwise both are 0.
- Latency: let edge k be the first clk edge that samples d_in=1 with d_in then held. q, rise and count update at edge k+STABLE_CYCLES+2. Example: STABLE_CYCLES=4 gives edge k+6. Falling transitions have the same latency.
- Glitch rejection: a level held for fewer than STABLE_CYCLES+1 consecutive s2 samples never changes q.
- count wraps from 2^EV_W-1 to 0 with no flag.
- All outputs are driven directly from registers; there are no combinational paths from d_in to any output.

Test Plan:
1. Reset/idle: assert rst for 2 cycles with d_in=0, then hold 10 cycles -> q=0, rise=0, fall=0, count=0 throughout.
2. Clean press (STABLE_CYCLES=4, 10 ns clock): d_in 0->1 at 12 ns (first sampling edge 15 ns) -> q=1 and rise=1 at the 75 ns edge, rise=0 at 85 ns, count=1. Releasing d_in gives q=0 and fall=1 six edges after the first sampling edge of 0; count stays 1.
3. Bounce: toggle d_in every 10 ns for 60 ns, then hold 1 -> q does not rise until 6 edges after the last toggle; exactly one rise pulse; count increments by exactly 1.
4. Short glitch: d_in=1 for 30 ns (3 sampled cycles), then 0 -> q stays 0, no rise or fall pulse, count unchanged.
5. Reset mid-wait: start a press, assert rst for 1 cycle at cycle 3 of ESPERA_ALTO -> q=0, count=0 after reset. With d_in still held at 1, q rises STABLE_CYCLES+2 edges after reset is released.
6. Wrap (EV_W=2): perform 5 clean presses -> count sequence 1,2,3,0,1 with one rise pulse per press.

Source files
------------

// File: rtl/antirrebote_d.sv
// Debounces a raw bouncy input into a clean synchronized level for flip_flop_d.
// Also emits one-cycle rise/fall pulses and a wrapping count of accepted rises.
module antirrebote_d #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3,
  parameter int unsigned EV_W          = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            d_in,
  output logic            q,
  output logic            rise,
  output logic            fall,
  output logic [EV_W-1:0] count
);

  typedef enum logic [1:0] {
    ESTABLE_BAJO,
    ESPERA_ALTO,
    ESTABLE_ALTO,
    ESPERA_BAJO
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= ESTABLE_BAJO;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      count <= '0;
    end else begin
      s1   <= d_in;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        ESTABLE_BAJO: begin
          if (s2) begin
            state <= ESPERA_ALTO;
            cnt   <= '0;
          end
        end
        ESPERA_ALTO: begin
          if (!s2) begin
            state <= ESTABLE_BAJO;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= ESTABLE_ALTO;
            q     <= 1'b1;
            rise  <= 1'b1;
            count <= count + EV_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ESTABLE_ALTO: begin
          if (!s2) begin
            state <= ESPERA_BAJO;
            cnt   <= '0;
          end
        end
        ESPERA_BAJO: begin
          // a 1 seen while waiting means the low level bounced
          if (s2) begin
            state <= ESTABLE_ALTO;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= ESTABLE_BAJO;
            q     <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ESTABLE_BAJO;
      endcase
    end
  end

endmodule

// File: tb/tb_antirrebote_d.sv
// Directed bench for antirrebote_d: reset, clean edges, bounce, glitch,
// reset mid-wait and event-counter wrap on a narrow second instance.
module tb_antirrebote_d;

  logic       clk;
  logic       rst;
  logic       d_in;
  logic       q;
  logic       rise;
  logic       fall;
  logic [7:0] count;
  logic       q2;
  logic       rise2;
  logic       fall2;
  logic [1:0] count2;

  int errs;
  int checks;
  int rises;
  int falls;

  antirrebote_d #(
    .STABLE_CYCLES(4),
    .CNT_W(3),
    .EV_W(8)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .d_in(d_in),
    .q(q),
    .rise(rise),
    .fall(fall),
    .count(count)
  );

  antirrebote_d #(
    .STABLE_CYCLES(4),
    .CNT_W(3),
    .EV_W(2)
  ) u_dut2 (
    .clk(clk),
    .rst(rst),
    .d_in(d_in),
    .q(q2),
    .rise(rise2),
    .fall(fall2),
    .count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance n edges, sample 1ns after each, tally pulses
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rise) rises++;
      if (fall) falls++;
      chk("excl", {31'd0, rise & fall}, 32'd0);
    end
  endtask

  logic [1:0] wrap_exp [5];

  initial begin
    errs   = 0;
    checks = 0;
    rises  = 0;
    falls  = 0;
    wrap_exp[0] = 2'd1;
    wrap_exp[1] = 2'd2;
    wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0;
    wrap_exp[4] = 2'd1;
    rst  = 1'b1;
    d_in = 1'b0;
    @(posedge clk);
    #1;
    tick(2);
    chk("rst_q", {31'd0, q}, 32'd0);
    chk("rst_pulse", {30'd0, rise, fall}, 32'd0);
    chk("rst_count", {24'd0, count}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle", {21'd0, q, rise, fall, count}, 32'd0);
    end

    // clean press and release
    rises = 0;
    falls = 0;
    d_in  = 1'b1;
    tick(6);
    chk("press_wait_q", {31'd0, q}, 32'd0);
    tick(1);
    chk("press_q", {31'd0, q}, 32'd1);
    chk("press_rise", {31'd0, rise}, 32'd1);
    chk("press_count", {24'd0, count}, 32'd1);
    tick(1);
    chk("press_rise_off", {31'd0, rise}, 32'd0);
    chk("press_hold_q", {31'd0, q}, 32'd1);
    d_in = 1'b0;
    tick(6);
    chk("rel_wait_q", {31'd0, q}, 32'd1);
    tick(1);
    chk("rel_q", {31'd0, q}, 32'd0);
    chk("rel_fall", {31'd0, fall}, 32'd1);
    chk("rel_count", {24'd0, count}, 32'd1);
    tick(1);
    chk("rel_fall_off", {31'd0, fall}, 32'd0);
    chk("rel_pulses", rises * 16 + falls, 32'h11);

    // bounce: one-sample levels, then hold high
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      d_in = (i % 2 == 0);
      tick(1);
    end
    d_in = 1'b1;
    tick(6);
    chk("bounce_wait_q", {31'd0, q}, 32'd0);
    chk("bounce_no_rise", rises, 32'd0);
    tick(1);
    chk("bounce_q", {31'd0, q}, 32'd1);
    tick(3);
    chk("bounce_rises", rises, 32'd1);
    chk("bounce_count", {24'd0, count}, 32'd2);
    d_in = 1'b0;
    tick(9);
    chk("bounce_rel_q", {31'd0, q}, 32'd0);

    // short glitch: 3 sampled cycles high
    rises = 0;
    falls = 0;
    d_in  = 1'b1;
    tick(3);
    d_in = 1'b0;
    tick(10);
    chk("glitch_q", {31'd0, q}, 32'd0);
    chk("glitch_pulses", rises + falls, 32'd0);
    chk("glitch_count", {24'd0, count}, 32'd2);

    // reset while waiting for the high level
    d_in = 1'b1;
    tick(5);
    chk("midwait_q", {31'd0, q}, 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_q", {31'd0, q}, 32'd0);
    chk("midrst_count", {24'd0, count}, 32'd0);
    tick(6);
    chk("postrst_wait_q", {31'd0, q}, 32'd0);
    tick(1);
    chk("postrst_q", {31'd0, q}, 32'd1);
    chk("postrst_rise", {31'd0, rise}, 32'd1);
    chk("postrst_count", {24'd0, count}, 32'd1);

    // wrap of the 2-bit event counter
    d_in = 1'b0;
    rst  = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("wrap_start", {30'd0, count2}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      d_in = 1'b1;
      tick(7);
      chk("wrap_rise", {31'd0, rise2}, 32'd1);
      chk("wrap_count", {30'd0, count2}, {30'd0, wrap_exp[i]});
      d_in = 1'b0;
      tick(8);
      chk("wrap_rel_q", {31'd0, q2}, 32'd0);
    end
    chk("wide_count", {24'd0, count}, 32'd5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
